// File: rtl/gray_seq_source.sv
// Gray-coded up/down counter presented on a valid/ready stream.
// gray_out and count_bin are registered together from one next-count value.
module gray_seq_source #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] count_bin,
   output logic             tc
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_gray;
   logic [WIDTH-1:0] w_count_nxt;

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1'b1);
   endfunction

   // State and count/gray registers; gray is always derived from the same next count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_count <= ZERO;
         r_gray  <= ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
         r_gray  <= bin2gray(w_count_nxt);
      end
   end

   // Next-state and next-count: load beats advance, advance beats start
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      if (load) begin
         w_state_nxt = ST_RUN;
         w_count_nxt = load_bin;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (en) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (out_ready) begin
                  if (up_dn) begin
                     w_count_nxt = r_count + ONE;
                  end else begin
                     w_count_nxt = r_count - ONE;
                  end
                  // a word taken with en low closes the stream; the advanced count waits
                  if (en) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign out_valid = (r_state == ST_RUN);
   assign gray_out  = r_gray;
   assign count_bin = r_count;
   assign tc        = out_valid && ((up_dn && (r_count == ALL_ONES)) ||
                                    (!up_dn && (r_count == ZERO)));

endmodule
